// File: rtl/branch_target_buffer_if.sv
// Fetch/train bus of the branch target buffer: lookup port, update port,
// flush control and the hit statistics counter.
interface branch_target_buffer_if;
    logic [31:0] lookup_pc;
    logic        hit;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush_all;
    logic [15:0] hit_count;
    logic        count_en;

    // Pipeline side: drives lookups/updates, consumes the prediction.
    modport master (
        output lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush_all, count_en,
        input  hit, pred_target, hit_count
    );

    // Buffer side.
    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush_all, count_en,
        output hit, pred_target, hit_count
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup with the fetch PC,
// registered training from resolved branches, saturating hit counter.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input logic                  CLK,
    input logic                  nRST,
    branch_target_buffer_if.slave bus
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [29:0]        targets [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_match;
    logic               unused_low_bits;

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[31:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[31:IDX_W+2];

    // Byte-offset bits are implied zero for PCs and targets.
    assign unused_low_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

    // Lookup and training-match logic; reads see pre-update contents (no bypass).
    always_comb begin
        bus.hit         = 1'b0;
        bus.pred_target = '0;
        up_match        = valid[up_idx] && (tags[up_idx] == up_tag);
        if (valid[lk_idx] && (tags[lk_idx] == lk_tag)) begin
            bus.hit         = 1'b1;
            bus.pred_target = {targets[lk_idx], 2'b00};
        end
    end

    // Valid bits: reset and flush clear all, taken allocates, not-taken on a match evicts.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
        end else if (bus.flush_all) begin
            valid <= '0;
        end else if (bus.upd_en) begin
            if (bus.upd_taken) begin
                valid[up_idx] <= 1'b1;
            end else if (up_match) begin
                valid[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload; meaningful only while the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (bus.upd_en && bus.upd_taken) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= bus.upd_target[31:2];
        end
    end

    // Saturating count of hitting lookups while fetch is not stalled.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            bus.hit_count <= '0;
        end else if (bus.count_en && bus.hit && (bus.hit_count != '1)) begin
            bus.hit_count <= bus.hit_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    branch_target_buffer_if bus_if ();

    branch_target_buffer #(.ENTRIES(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus_if.upd_en     = 1'b1;
        bus_if.upd_pc     = pc;
        bus_if.upd_target = tgt;
        bus_if.upd_taken  = taken;
        tick();
        bus_if.upd_en     = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic [31:0] exp_tgt);
        bus_if.lookup_pc = pc;
        #1;
        check({tag, "_hit"}, {31'd0, bus_if.hit}, {31'd0, exp_hit});
        check({tag, "_tgt"}, bus_if.pred_target, exp_tgt);
    endtask

    initial begin
        nRST              = 1'b0;
        bus_if.lookup_pc  = 32'h40;
        bus_if.upd_en     = 1'b0;
        bus_if.upd_pc     = '0;
        bus_if.upd_target = '0;
        bus_if.upd_taken  = 1'b0;
        bus_if.flush_all  = 1'b0;
        bus_if.count_en   = 1'b0;
        repeat (2) tick();
        nRST = 1'b1;

        // 1. reset state
        look("rst", 32'h40, 1'b0, 32'h0);
        check("rst_cnt", {16'd0, bus_if.hit_count}, 32'd0);

        // 2. train and lookup, no bypass in the update cycle
        bus_if.upd_en     = 1'b1;
        bus_if.upd_pc     = 32'h40;
        bus_if.upd_target = 32'h80;
        bus_if.upd_taken  = 1'b1;
        look("same_cyc", 32'h40, 1'b0, 32'h0);
        tick();
        bus_if.upd_en = 1'b0;
        look("trained", 32'h40, 1'b1, 32'h80);

        // 3. alias at index 0 overwrites
        train(32'h80, 32'h100, 1'b1);
        look("alias_old", 32'h40, 1'b0, 32'h0);
        look("alias_new", 32'h80, 1'b1, 32'h100);

        // low target bits dropped
        train(32'h48, 32'h303, 1'b1);
        look("lowbits", 32'h48, 1'b1, 32'h300);

        // 4. not-taken evicts on match, no change on mismatch
        train(32'h44, 32'h200, 1'b1);
        look("t44", 32'h44, 1'b1, 32'h200);
        train(32'h44, 32'h0, 1'b0);
        look("evict", 32'h44, 1'b0, 32'h0);
        train(32'h44, 32'h200, 1'b1);
        train(32'h84, 32'h999, 1'b0);
        look("nt_mismatch", 32'h44, 1'b1, 32'h200);
        look("nt_noalloc", 32'h84, 1'b0, 32'h0);

        // hit counting: 3 hitting cycles, then 2 missing cycles
        bus_if.lookup_pc = 32'h44;
        bus_if.count_en  = 1'b1;
        repeat (3) tick();
        bus_if.count_en  = 1'b0;
        check("cnt3", {16'd0, bus_if.hit_count}, 32'd3);
        bus_if.lookup_pc = 32'h84;
        bus_if.count_en  = 1'b1;
        repeat (2) tick();
        bus_if.count_en  = 1'b0;
        check("cnt_miss", {16'd0, bus_if.hit_count}, 32'd3);

        // 5. flush dominates a simultaneous taken update
        bus_if.flush_all = 1'b1;
        train(32'h4C, 32'h400, 1'b1);
        bus_if.flush_all = 1'b0;
        look("fl40", 32'h40, 1'b0, 32'h0);
        look("fl44", 32'h44, 1'b0, 32'h0);
        look("fl48", 32'h48, 1'b0, 32'h0);
        look("fl4c", 32'h4C, 1'b0, 32'h0);
        look("fl80", 32'h80, 1'b0, 32'h0);
        check("fl_cnt", {16'd0, bus_if.hit_count}, 32'd3);

        // 6. saturation, then reset discarding a concurrent update
        train(32'h40, 32'h80, 1'b1);
        bus_if.lookup_pc = 32'h40;
        bus_if.count_en  = 1'b1;
        repeat (70000) @(posedge CLK);
        #1;
        check("sat", {16'd0, bus_if.hit_count}, 32'h0000FFFF);
        bus_if.count_en = 1'b0;
        nRST = 1'b0;
        train(32'h50, 32'h500, 1'b1);
        nRST = 1'b1;
        check("rst2_cnt", {16'd0, bus_if.hit_count}, 32'd0);
        look("rst2_40", 32'h40, 1'b0, 32'h0);
        look("rst2_50", 32'h50, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
